maze_solver_ctrl: RTL and testbench
===================================

Name: maze_solver_ctrl

Overview:
- FSM that sequences the 16x16 maze bit-memory to solve the rat-in-maze problem by depth-first search with backtracking.
- Starts at cell (0,0) and searches for the goal (15,15). Map bit 1 = wall, 0 = free.
- Marks each visited cell by writing 1 into the map.
- Sits between the top-level start/status interface and the maze memory; it is the memory's only master.

Parameters:
- STACK_DEPTH, 256, max entries in the direction stack (one per forward move).
- GOAL_X, 15, goal column.
- GOAL_Y, 15, goal row.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a solve from IDLE, DONE or FAIL.
- mem_loc  out  8  cell address {y[3:0], x[3:0]} to the memory.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_din  out  1  memory write data.
- mem_dout  in  1  memory read data.
- done  out  1  level; goal reached.
- fail  out  1  level; search exhausted, no path.
- path_len  out  9  number of moves on the found path (stack pointer).

Behaviour:
- Reset (asynchronous, any state): state=IDLE. Every output is 0: mem_loc, mem_rd, mem_wr, mem_din, done, fail, path_len. Stack pointer sp=0. Map contents are not restored.
- Directions (2-bit): 0 = +x, 1 = +y, 2 = -x, 3 = -y. Tried in order 0..3.
- Registers: cur{y,x}, dir, sp.

State machine:
- IDLE: on start, cur=(0,0), dir=0, sp=0, clear done/fail, go to MARK.
- MARK: mem_wr=1, mem_din=1, mem_loc=cur for one cycle.
  - If cur=={GOAL_Y,GOAL_X}, go to DONE.
  - Otherwise go to TRY.
- TRY: compute nbr = cur + step(dir).
  - Out of grid (x or y would leave 0..15, no wrap-around): no memory access, go to NEXT.
  - In grid: mem_rd=1, mem_loc=nbr for exactly one cycle, go to WAIT.
- WAIT: mem_rd=0. Sample mem_dout (memory data is valid in the cycle after the rd cycle, then clears).
  - 0: push dir, sp++, cur=nbr, dir=0, go to MARK.
  - 1: go to NEXT.
- NEXT:
  - dir==3: go to BACK.
  - Otherwise dir++ and go to TRY.
- BACK:
  - sp==0: go to FAIL.
  - Otherwise pop d, sp--, cur = cur - step(d), dir=d, go to NEXT.
- DONE: done=1, path_len=sp. Held until start or rst. start re-enters MARK flow from (0,0) on the now-marked map.
- FAIL: fail=1, path_len=0. Held until start or rst.

Rules:
- start is ignored outside IDLE, DONE and FAIL.
- mem_rd and mem_wr are never asserted in the same cycle, and each is at most one cycle wide.
- Memory contract: a read strobe for address A yields map bit A on the next cycle; the write lands on the clock edge ending MARK.
- Latency per forward move through a free in-grid neighbour at dir=0: 3 cycles (MARK, TRY, WAIT).
- Each rejected direction costs 3 cycles if in grid (TRY, WAIT, NEXT) or 2 cycles if out of grid (TRY, NEXT).
- A backtrack costs 2 cycles (BACK, NEXT).
- The start cell is marked without being read; a wall bit at (0,0) is overwritten.
- Visited marking guarantees termination. The stack depth never exceeds 255 for a 16x16 grid, so there is no overflow condition; STACK_DEPTH only sizes the storage.
- Stack pop with sp==0 is impossible by construction; the sp==0 test precedes any pop.

Decomposition:
- Shared package holds:
  - Direction codes (DIR_XP, DIR_YP, DIR_XN, DIR_YN).
  - State encoding.
  - GRID_SIZE=16 and START cell constant.
  - A step/inverse-step function returning the {dy,dx} delta and an in-bounds flag.
- One sub-module: dir_stack, a synchronous LIFO with 2-bit width and STACK_DEPTH depth.
  - Ports: push, pop, din, dout, sp; async reset of sp only.

Test Plan:
- All-zero map, start pulse -> mem_wr pulses on 31 distinct cells (x=0..15 at y=0, then y=1..15 at x=15); done=1, path_len=30, fail=0.
- Map with row y=1 all walls except x=15 -> path along y=0 to x=15, then down; done=1, path_len=30; no reads issued for x<15 in +y direction succeed.
- Map with (1,0) and (0,1) walls -> after reads at loc 8'h01 and 8'h10 return 1, BACK with sp==0; fail=1, done=0, path_len=0.
- Dead-end corridor forcing 3-deep backtrack then alternate route -> done=1; path_len equals hand-computed route length (no dead-end moves counted); the stack trace matches the push/pop sequence.
- Assert rst during WAIT mid-solve -> all outputs 0 immediately; a following start re-solves on the partially marked map and reaches the expected done/fail.
- start pulse while in TRY -> ignored: no state change, no extra memory access.

Source files
------------

// File: rtl/maze_solver_ctrl_pkg.sv
// maze_solver_ctrl_pkg
//   Shared definitions for the maze solver controller: direction codes,
//   FSM state encoding, grid constants and the neighbour-step helpers.
//   A cell address is {y[3:0], x[3:0]}.
package maze_solver_ctrl_pkg;

  localparam int         GRID_SIZE  = 16;
  localparam logic [3:0] GRID_MAX   = 4'(GRID_SIZE - 1);
  localparam logic [7:0] START_CELL = 8'h00;

  // Direction codes, tried in this numeric order at every cell.
  localparam logic [1:0] DIR_XP = 2'd0;
  localparam logic [1:0] DIR_YP = 2'd1;
  localparam logic [1:0] DIR_XN = 2'd2;
  localparam logic [1:0] DIR_YN = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_TRY,
    ST_WAIT,
    ST_NEXT,
    ST_BACK,
    ST_DONE,
    ST_FAIL
  } state_t;

  // Neighbour cell plus an in-grid flag (no wrap-around at the edges).
  typedef struct packed {
    logic       ok;
    logic [3:0] y;
    logic [3:0] x;
  } step_t;

  function automatic step_t step_cell(input logic [3:0] y, input logic [3:0] x,
                                      input logic [1:0] dir);
    step_t r;
    r.ok = 1'b1;
    r.y  = y;
    r.x  = x;
    case (dir)
      DIR_XP: begin r.ok = (x != GRID_MAX); r.x = x + 4'd1; end
      DIR_YP: begin r.ok = (y != GRID_MAX); r.y = y + 4'd1; end
      DIR_XN: begin r.ok = (x != 4'd0);     r.x = x - 4'd1; end
      default: begin r.ok = (y != 4'd0);    r.y = y - 4'd1; end
    endcase
    return r;
  endfunction

  // Undo a forward move taken in direction dir. Only used when popping a
  // move that was actually taken, so the result is always in the grid.
  function automatic logic [7:0] unstep_cell(input logic [3:0] y, input logic [3:0] x,
                                             input logic [1:0] dir);
    logic [3:0] ny;
    logic [3:0] nx;
    ny = y;
    nx = x;
    case (dir)
      DIR_XP:  nx = x - 4'd1;
      DIR_YP:  ny = y - 4'd1;
      DIR_XN:  nx = x + 4'd1;
      default: ny = y + 4'd1;
    endcase
    return {ny, nx};
  endfunction

endpackage

// File: rtl/maze_solver_ctrl_stack.sv
// dir_stack
//   Synchronous LIFO of 2-bit directions, one entry per forward move.
//   Ports:
//     clk, rst  clock, asynchronous active-high reset (clears sp only)
//     clr       synchronous clear of the stack pointer (new solve)
//     push, din push din on the clock edge
//     pop       drop the top entry on the clock edge
//     dout      current top entry (combinational, valid while sp != 0)
//     sp        number of entries held
module dir_stack #(
  parameter int DEPTH = 256,
  parameter int SPW   = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           push,
  input  logic           pop,
  input  logic [1:0]     din,
  output logic [1:0]     dout,
  output logic [SPW-1:0] sp
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]     mem [DEPTH];
  logic [SPW-1:0] top_idx;

  assign top_idx = sp - SPW'(1);
  assign dout    = mem[top_idx[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + SPW'(1);
    end else if (pop) begin
      sp <= sp - SPW'(1);
    end
  end

  // Storage has no reset: stale entries above sp are never read.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[sp[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/maze_solver_ctrl.sv
// maze_solver_ctrl
//   Depth-first rat-in-maze solver over a 16x16 bit map (1 = wall/visited,
//   0 = free). Starts at (0,0), marks every visited cell by writing 1, and
//   backtracks through a direction stack until the goal is reached or the
//   search is exhausted. Sole master of the maze memory.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     start      one-cycle pulse, honoured in IDLE, DONE and FAIL only
//     mem_loc    cell address {y,x}; mem_rd / mem_wr / mem_din strobes
//     mem_dout   read data, valid the cycle after mem_rd
//     done, fail result levels held until the next start or reset
//     path_len   moves on the found path (0 unless done)
//   Memory handshake: a mem_rd pulse for address A is answered by map[A]
//   on mem_dout in the following cycle with no back-pressure; a mem_wr
//   pulse commits mem_din at the clock edge ending that cycle. The two
//   strobes are never high together and each is one cycle wide.
//   The current FSM state is visible as state_q for observation.
module maze_solver_ctrl
  import maze_solver_ctrl_pkg::*;
#(
  parameter int STACK_DEPTH = 256,
  parameter int GOAL_X      = 15,
  parameter int GOAL_Y      = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] mem_loc,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_din,
  input  logic       mem_dout,
  output logic       done,
  output logic       fail,
  output logic [8:0] path_len
);

  localparam logic [7:0] GOAL_CELL = {4'(GOAL_Y), 4'(GOAL_X)};

  state_t     state_q, state_d;
  logic [3:0] cur_y_q, cur_y_d;
  logic [3:0] cur_x_q, cur_x_d;
  logic [1:0] dir_q, dir_d;

  logic       stk_clr, stk_push, stk_pop;
  logic [1:0] stk_dout;
  logic [8:0] sp;

  step_t      nbr;
  logic [7:0] back_cell;

  dir_stack #(
    .DEPTH (STACK_DEPTH),
    .SPW   (9)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .clr  (stk_clr),
    .push (stk_push),
    .pop  (stk_pop),
    .din  (dir_q),
    .dout (stk_dout),
    .sp   (sp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_y_q <= '0;
      cur_x_q <= '0;
      dir_q   <= DIR_XP;
    end else begin
      state_q <= state_d;
      cur_y_q <= cur_y_d;
      cur_x_q <= cur_x_d;
      dir_q   <= dir_d;
    end
  end

  // cur and dir stay put through TRY/WAIT, so the neighbour computed here
  // is the same one that was read in TRY when WAIT consumes the data.
  assign nbr       = step_cell(cur_y_q, cur_x_q, dir_q);
  assign back_cell = unstep_cell(cur_y_q, cur_x_q, stk_dout);

  always_comb begin
    state_d  = state_q;
    cur_y_d  = cur_y_q;
    cur_x_d  = cur_x_q;
    dir_d    = dir_q;
    stk_clr  = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    mem_loc  = '0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_din  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_d = ST_MARK;
          cur_y_d = START_CELL[7:4];
          cur_x_d = START_CELL[3:0];
          dir_d   = DIR_XP;
          stk_clr = 1'b1;
        end
      end

      ST_MARK: begin
        mem_wr  = 1'b1;
        mem_din = 1'b1;
        mem_loc = {cur_y_q, cur_x_q};
        if ({cur_y_q, cur_x_q} == GOAL_CELL) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_TRY;
        end
      end

      ST_TRY: begin
        if (nbr.ok) begin
          mem_rd  = 1'b1;
          mem_loc = {nbr.y, nbr.x};
          state_d = ST_WAIT;
        end else begin
          state_d = ST_NEXT;
        end
      end

      ST_WAIT: begin
        if (!mem_dout) begin
          stk_push = 1'b1;
          cur_y_d  = nbr.y;
          cur_x_d  = nbr.x;
          dir_d    = DIR_XP;
          state_d  = ST_MARK;
        end else begin
          state_d = ST_NEXT;
        end
      end

      ST_NEXT: begin
        if (dir_q == DIR_YN) begin
          state_d = ST_BACK;
        end else begin
          dir_d   = dir_q + 2'd1;
          state_d = ST_TRY;
        end
      end

      ST_BACK: begin
        if (sp == '0) begin
          state_d = ST_FAIL;
        end else begin
          // Resume at the parent with the direction that led here, so NEXT
          // moves on to the following untried direction.
          stk_pop = 1'b1;
          cur_y_d = back_cell[7:4];
          cur_x_d = back_cell[3:0];
          dir_d   = stk_dout;
          state_d = ST_NEXT;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign done     = (state_q == ST_DONE);
  assign fail     = (state_q == ST_FAIL);
  assign path_len = done ? sp : 9'd0;

endmodule

// File: tb/tb_maze_solver_ctrl.sv
// tb_maze_solver_ctrl
//   Directed bench for maze_solver_ctrl with a behavioural maze memory,
//   a strobe monitor and a write-order scoreboard.
module tb_maze_solver_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] mem_loc;
  logic       mem_rd;
  logic       mem_wr;
  logic       mem_din;
  logic       mem_dout = 1'b0;
  logic       done;
  logic       fail;
  logic [8:0] path_len;

  int test_cnt = 0;
  int fail_cnt = 0;

  logic       map [256];
  logic [7:0] wr_q  [$];
  logic [7:0] exp_q [$];
  int         rd_cnt, row1_rd, overlap_cnt, wide_cnt;
  logic       prev_rd = 1'b0, prev_wr = 1'b0;

  maze_solver_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_loc  (mem_loc),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .done     (done),
    .fail     (fail),
    .path_len (path_len)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- maze memory model ----------------
  always @(posedge clk) begin
    mem_dout <= mem_rd ? map[mem_loc] : 1'b0;
    if (mem_wr) map[mem_loc] <= mem_din;
  end

  // ---------------- strobe monitor ----------------
  always @(negedge clk) begin
    if (mem_wr) wr_q.push_back(mem_loc);
    if (mem_rd) begin
      rd_cnt++;
      if (mem_loc[7:4] == 4'd1 && mem_loc[3:0] != 4'd15) row1_rd++;
    end
    if (mem_rd && mem_wr) overlap_cnt++;
    if ((mem_rd && prev_rd) || (mem_wr && prev_wr)) wide_cnt++;
    prev_rd = mem_rd;
    prev_wr = mem_wr;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, wr_q.size(), exp_q.size());
    if (wr_q.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_strobes(input string tag);
    check({tag, "_rd_wr_overlap"}, overlap_cnt, 0);
    check({tag, "_strobe_width"}, wide_cnt, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_map(input logic v);
    for (int i = 0; i < 256; i++) map[i] = v;
  endtask

  task automatic clear_monitor();
    wr_q.delete();
    exp_q.delete();
    rd_cnt      = 0;
    row1_rd     = 0;
    overlap_cnt = 0;
    wide_cnt    = 0;
  endtask

  // Pulse start, then count cycles until done/fail (bounded). n==0 is the
  // first MARK cycle. If extra_n > 0 a second start pulse is driven while
  // the DUT sits at that cycle count.
  task automatic run_solve(input int extra_n, output int n);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!(done || fail) && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == extra_n);
    end
    start = 1'b0;
  endtask

  int n;

  initial begin
    // ---------------- reset ----------------
    rst   = 1'b1;
    start = 1'b0;
    fill_map(1'b0);
    clear_monitor();
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_loc", mem_loc, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_path_len", path_len, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- test 1: open map, stray start during TRY ----------------
    clear_monitor();
    for (int x = 0; x < 16; x++) exp_q.push_back({4'd0, 4'(x)});
    for (int y = 1; y < 16; y++) exp_q.push_back({4'(y), 4'd15});
    run_solve(1, n);
    check("t1_cycles", n, 121);
    check("t1_done", done, 1);
    check("t1_fail", fail, 0);
    check("t1_path_len", path_len, 30);
    check("t1_reads", rd_cnt, 30);
    check_writes("t1");
    check_strobes("t1");
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_hold", done, 1);
    check("t1_len_hold", path_len, 30);
    check("t1_idle_writes", wr_q.size(), 31);

    // ---------------- test 2: row y=1 walled except x=15 ----------------
    fill_map(1'b0);
    for (int x = 0; x < 15; x++) map[{4'd1, 4'(x)}] = 1'b1;
    clear_monitor();
    run_solve(0, n);
    check("t2_cycles", n, 121);
    check("t2_done", done, 1);
    check("t2_path_len", path_len, 30);
    check("t2_reads", rd_cnt, 30);
    check("t2_row1_reads", row1_rd, 0);
    check_strobes("t2");

    // ---------------- test 3: boxed-in start ----------------
    fill_map(1'b0);
    map[8'h01] = 1'b1;
    map[8'h10] = 1'b1;
    clear_monitor();
    exp_q.push_back(8'h00);
    run_solve(0, n);
    check("t3_cycles", n, 12);
    check("t3_fail", fail, 1);
    check("t3_done", done, 0);
    check("t3_path_len", path_len, 0);
    check("t3_reads", rd_cnt, 2);
    check_writes("t3");
    check_strobes("t3");

    // ---------------- test 4: 3-deep dead end then column route ----------------
    fill_map(1'b1);
    map[8'h00] = 1'b0;
    map[8'h01] = 1'b0;
    map[8'h02] = 1'b0;
    map[8'h03] = 1'b0;
    for (int y = 1; y < 16; y++) map[{4'(y), 4'd0}] = 1'b0;
    for (int x = 1; x < 16; x++) map[{4'd15, 4'(x)}] = 1'b0;
    clear_monitor();
    for (int x = 0; x < 4; x++) exp_q.push_back({4'd0, 4'(x)});
    for (int y = 1; y < 16; y++) exp_q.push_back({4'(y), 4'd0});
    for (int x = 1; x < 16; x++) exp_q.push_back({4'd15, 4'(x)});
    run_solve(0, n);
    check("t4_done", done, 1);
    check("t4_fail", fail, 0);
    check("t4_path_len", path_len, 30);
    check("t4_reads", rd_cnt, 54);
    check_writes("t4");
    check_strobes("t4");

    // ---------------- test 5: reset during WAIT, then re-solve ----------------
    fill_map(1'b0);
    clear_monitor();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (n < 19) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_try_rd", mem_rd, 1);
    check("t5_try_loc", mem_loc, 8'h07);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_mem_loc", mem_loc, 0);
    check("t5_rst_rd_wr", {mem_rd, mem_wr, mem_din}, 0);
    check("t5_rst_done_fail", {done, fail}, 0);
    check("t5_rst_path_len", path_len, 0);
    @(negedge clk) rst = 1'b0;
    clear_monitor();
    repeat (4) @(negedge clk);
    check("t5_idle_no_access", rd_cnt + wr_q.size(), 0);
    run_solve(0, n);
    check("t5_cycles", n, 122);
    check("t5_done", done, 1);
    check("t5_path_len", path_len, 30);
    check_strobes("t5");

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
